// File: rtl/time_counter_if.sv
// rtl/time_counter_if.sv - signal bundle between the seconds divider/load source and the time counter
//
// Purpose: groups the secclk input, run/load controls, load data and the
//          BCD time and pulse outputs of time_counter.
// Signals:
//   secclk                    divider square wave (async to clk)
//   run_en                    1 = count seconds, 0 = drop ticks
//   load, ld_h, ld_m, ld_s    single-cycle load request and BCD load values
//   hours, minutes, seconds   BCD time
//   sec_pulse, min_pulse,
//   hour_pulse, day_pulse     one-cycle carry pulses
//   load_err                  one-cycle pulse on a rejected load
// Modports: master drives controls/load data; slave is the counter.
interface time_counter_if;
  logic       secclk;
  logic       run_en;
  logic       load;
  logic [7:0] ld_h;
  logic [7:0] ld_m;
  logic [7:0] ld_s;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       sec_pulse;
  logic       min_pulse;
  logic       hour_pulse;
  logic       day_pulse;
  logic       load_err;

  modport master (
    output secclk, run_en, load, ld_h, ld_m, ld_s,
    input  hours, minutes, seconds,
    input  sec_pulse, min_pulse, hour_pulse, day_pulse, load_err
  );

  modport slave (
    input  secclk, run_en, load, ld_h, ld_m, ld_s,
    output hours, minutes, seconds,
    output sec_pulse, min_pulse, hour_pulse, day_pulse, load_err
  );
endinterface

// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD hh:mm:ss timekeeping core driven by secclk rising edges
//
// Purpose: synchronises secclk into clk, detects rising edges, advances a BCD
//          23:59:59 counter with same-cycle carry ripple, accepts validated
//          time loads and emits registered one-cycle carry pulses.
// Ports:
//   clk    system clock, all state on its rising edge
//   reset  synchronous active-high reset
//   bus    time_counter_if.slave (secclk, run_en, load data, time and pulses)
module time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  time_counter_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;

  logic [7:0] hours_q;
  logic [7:0] minutes_q;
  logic [7:0] seconds_q;
  logic       sec_pulse_q;
  logic       min_pulse_q;
  logic       hour_pulse_q;
  logic       day_pulse_q;
  logic       load_err_q;

  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic [7:0] sec_next;
  logic [7:0] min_next;
  logic [7:0] hour_next;
  logic       load_valid;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // sync_q[last] is s2, edge_q is s3; only rising edges give a tick.
  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q & bus.run_en;

  // Carries ripple combinationally so 23:59:59 -> 00:00:00 in one edge.
  always_comb begin
    sec_wrap  = (seconds_q == 8'h59);
    min_wrap  = sec_wrap && (minutes_q == 8'h59);
    hour_wrap = min_wrap && (hours_q == 8'h23);
    sec_next  = sec_wrap ? 8'h00 : bcd_inc(seconds_q);
    min_next  = minutes_q;
    if (sec_wrap)
      min_next = (minutes_q == 8'h59) ? 8'h00 : bcd_inc(minutes_q);
    hour_next = hours_q;
    if (min_wrap)
      hour_next = (hours_q == 8'h23) ? 8'h00 : bcd_inc(hours_q);
  end

  assign load_valid = digits_ok(bus.ld_h) && digits_ok(bus.ld_m) && digits_ok(bus.ld_s) &&
                      (bus.ld_h <= 8'h23) && (bus.ld_m <= 8'h59) && (bus.ld_s <= 8'h59);

  always_ff @(posedge clk) begin
    if (reset) begin
      // Chain preset high so a secclk held high through reset is not a tick.
      sync_q       <= '1;
      edge_q       <= 1'b1;
      hours_q      <= 8'h00;
      minutes_q    <= 8'h00;
      seconds_q    <= 8'h00;
      sec_pulse_q  <= 1'b0;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      // The chain keeps shifting even when run_en is low, so no stale tick on re-enable.
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.secclk};
      edge_q       <= sync_q[SYNC_STAGES-1];
      sec_pulse_q  <= 1'b0;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
      load_err_q   <= 1'b0;
      if (bus.load && load_valid) begin
        // A valid load discards a coincident tick.
        hours_q   <= bus.ld_h;
        minutes_q <= bus.ld_m;
        seconds_q <= bus.ld_s;
      end else begin
        if (bus.load)
          load_err_q <= 1'b1;
        if (tick) begin
          seconds_q    <= sec_next;
          minutes_q    <= min_next;
          hours_q      <= hour_next;
          sec_pulse_q  <= 1'b1;
          min_pulse_q  <= sec_wrap;
          hour_pulse_q <= min_wrap;
          day_pulse_q  <= hour_wrap;
        end
      end
    end
  end

  assign bus.hours      = hours_q;
  assign bus.minutes    = minutes_q;
  assign bus.seconds    = seconds_q;
  assign bus.sec_pulse  = sec_pulse_q;
  assign bus.min_pulse  = min_pulse_q;
  assign bus.hour_pulse = hour_pulse_q;
  assign bus.day_pulse  = day_pulse_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - directed self-checking bench for time_counter
module tb_time_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   sec_cnt;
  int   c0;

  time_counter_if tc_if ();

  time_counter #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts sec_pulse cycles, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (tc_if.sec_pulse === 1'b1) sec_cnt++;
  end

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    tc_if.load = 1'b1;
    tc_if.ld_h = h;
    tc_if.ld_m = m;
    tc_if.ld_s = s;
    @(negedge clk);
    tc_if.load = 1'b0;
  endtask

  // Low for 4 cycles, then high; returns at the negedge after the update edge (N+2).
  task automatic rise3();
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    tc_if.secclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tc_if.secclk = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_time actual=%h required=000000", {tc_if.hours, tc_if.minutes, tc_if.seconds});
    end
    checks++;
    if ({tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse, tc_if.load_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses actual=%b required=00000",
               {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse, tc_if.load_err});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sec_cnt !== 0 || tc_if.seconds !== 8'h00) begin
      failures++;
      $display("FAIL no_tick_at_release actual pulses=%0d sec=%h required 0 / 00", sec_cnt, tc_if.seconds);
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 5; i++) begin
      tc_if.secclk = 1'b0;
      repeat (5) @(negedge clk);
      tc_if.secclk = 1'b1;
      @(negedge clk);
      checks++;
      if (tc_if.sec_pulse !== 1'b0) begin
        failures++;
        $display("FAIL count_lat_n actual=%b required=0", tc_if.sec_pulse);
      end
      @(negedge clk);
      checks++;
      if (tc_if.sec_pulse !== 1'b0) begin
        failures++;
        $display("FAIL count_lat_n1 actual=%b required=0", tc_if.sec_pulse);
      end
      @(negedge clk);
      checks++;
      if (tc_if.sec_pulse !== 1'b1) begin
        failures++;
        $display("FAIL count_lat_n2 actual=%b required=1", tc_if.sec_pulse);
      end
      @(negedge clk);
      checks++;
      if (tc_if.sec_pulse !== 1'b0) begin
        failures++;
        $display("FAIL count_width actual=%b required=0", tc_if.sec_pulse);
      end
      @(negedge clk);
    end
    checks++;
    if (tc_if.seconds !== 8'h05 || sec_cnt !== 5) begin
      failures++;
      $display("FAIL count_total actual sec=%h pulses=%0d required 05 / 5", tc_if.seconds, sec_cnt);
    end
  endtask

  task automatic test_rollover();
    do_load(8'h23, 8'h59, 8'h58);
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h235958 || tc_if.min_pulse !== 1'b0) begin
      failures++;
      $display("FAIL roll_load actual=%h required=235958", {tc_if.hours, tc_if.minutes, tc_if.seconds});
    end
    rise3();
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h235959 ||
        {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse} !== 4'b1000) begin
      failures++;
      $display("FAIL roll_first actual=%h pulses=%b required=235959 1000", {tc_if.hours, tc_if.minutes, tc_if.seconds},
               {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse});
    end
    rise3();
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h000000 ||
        {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse} !== 4'b1111) begin
      failures++;
      $display("FAIL roll_wrap actual=%h pulses=%b required=000000 1111", {tc_if.hours, tc_if.minutes, tc_if.seconds},
               {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse});
    end
    @(negedge clk);
    checks++;
    if ({tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse} !== 4'b0000) begin
      failures++;
      $display("FAIL roll_width actual=%b required=0000",
               {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse});
    end
  endtask

  task automatic test_invalid_load();
    logic [23:0] bad [3];
    bad[0] = 24'h240000;
    bad[1] = 24'h005A00;
    bad[2] = 24'h000060;
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_load(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      checks++;
      if (tc_if.load_err !== 1'b1 || {tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h000000) begin
        failures++;
        $display("FAIL bad_load_%0d actual err=%b time=%h required 1 / 000000", i, tc_if.load_err,
                 {tc_if.hours, tc_if.minutes, tc_if.seconds});
      end
      @(negedge clk);
      checks++;
      if (tc_if.load_err !== 1'b0) begin
        failures++;
        $display("FAIL bad_load_width_%0d actual=%b required=0", i, tc_if.load_err);
      end
    end
    do_load(8'h19, 8'h30, 8'h45);
    checks++;
    if (tc_if.load_err !== 1'b0 || {tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h193045) begin
      failures++;
      $display("FAIL good_load actual err=%b time=%h required 0 / 193045", tc_if.load_err,
               {tc_if.hours, tc_if.minutes, tc_if.seconds});
    end
  endtask

  task automatic test_collision();
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    tc_if.secclk = 1'b1;
    repeat (2) @(negedge clk);
    do_load(8'h12, 8'h00, 8'h00);
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h120000 || tc_if.sec_pulse !== 1'b0) begin
      failures++;
      $display("FAIL coll_valid actual time=%h pulse=%b required 120000 / 0", {tc_if.hours, tc_if.minutes, tc_if.seconds},
               tc_if.sec_pulse);
    end
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    tc_if.secclk = 1'b1;
    repeat (2) @(negedge clk);
    do_load(8'h24, 8'h00, 8'h00);
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h120001 || tc_if.sec_pulse !== 1'b1 ||
        tc_if.load_err !== 1'b1) begin
      failures++;
      $display("FAIL coll_invalid actual time=%h pulse=%b err=%b required 120001 / 1 / 1",
               {tc_if.hours, tc_if.minutes, tc_if.seconds}, tc_if.sec_pulse, tc_if.load_err);
    end
  endtask

  task automatic test_pause();
    c0 = sec_cnt;
    tc_if.run_en = 1'b0;
    repeat (3) rise3();
    repeat (2) @(negedge clk);
    tc_if.run_en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (sec_cnt !== c0 || {tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h120001) begin
      failures++;
      $display("FAIL pause_frozen actual pulses=%0d time=%h required %0d / 120001", sec_cnt - c0,
               {tc_if.hours, tc_if.minutes, tc_if.seconds}, 0);
    end
    rise3();
    checks++;
    if (tc_if.sec_pulse !== 1'b1 || tc_if.seconds !== 8'h02) begin
      failures++;
      $display("FAIL pause_resume actual pulse=%b sec=%h required 1 / 02", tc_if.sec_pulse, tc_if.seconds);
    end
  endtask

  task automatic test_hold_load();
    c0 = sec_cnt;
    tc_if.load = 1'b1;
    tc_if.ld_h = 8'h01;
    tc_if.ld_m = 8'h02;
    tc_if.ld_s = 8'h03;
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    tc_if.secclk = 1'b1;
    repeat (4) @(negedge clk);
    tc_if.load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sec_cnt !== c0 || {tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h010203) begin
      failures++;
      $display("FAIL hold_load actual pulses=%0d time=%h required 0 / 010203", sec_cnt - c0,
               {tc_if.hours, tc_if.minutes, tc_if.seconds});
    end
  endtask

  task automatic test_reset_mid_tick();
    tc_if.secclk = 1'b0;
    repeat (4) @(negedge clk);
    tc_if.secclk = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({tc_if.hours, tc_if.minutes, tc_if.seconds} !== 24'h000000 ||
        {tc_if.sec_pulse, tc_if.min_pulse, tc_if.hour_pulse, tc_if.day_pulse, tc_if.load_err} !== 5'b0) begin
      failures++;
      $display("FAIL midtick_reset actual time=%h required=000000", {tc_if.hours, tc_if.minutes, tc_if.seconds});
    end
    c0 = sec_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (sec_cnt !== c0 || tc_if.seconds !== 8'h00) begin
      failures++;
      $display("FAIL midtick_no_tick actual pulses=%0d sec=%h required 0 / 00", sec_cnt - c0, tc_if.seconds);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sec_cnt  = 0;
    reset    = 1'b1;
    tc_if.secclk = 1'b1;
    tc_if.run_en = 1'b1;
    tc_if.load   = 1'b0;
    tc_if.ld_h   = 8'h00;
    tc_if.ld_m   = 8'h00;
    tc_if.ld_s   = 8'h00;
    @(negedge clk);
    test_reset();
    test_count();
    test_rollover();
    test_invalid_load();
    test_collision();
    test_pause();
    test_hold_load();
    test_reset_mid_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping core fed by the divider's `secclk` square wave. Synchronises `secclk` into the `clk` domain and detects its rising edges. Advances a BCD hh:mm:ss counter by one second per rising edge. Supports a validated time load, and emits single-cycle carry pulses for the display and alarm logic downstream.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth ahead of the edge-detect register. The legal value is 2; all timing below assumes 2.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `secclk` in 1: divider square wave, asynchronous to `clk`; each rising edge is one second.
- `run_en` in 1: 1 = count seconds; 0 = drop ticks without queueing them.
- `load` in 1: single-cycle request to load `ld_h`/`ld_m`/`ld_s`.
- `ld_h` in 8: BCD hours as {tens, units}.
- `ld_m` in 8: BCD minutes.
- `ld_s` in 8: BCD seconds.
- `hours` out 8: BCD 00–23.
- `minutes` out 8: BCD 00–59.
- `seconds` out 8: BCD 00–59.
- `sec_pulse` out 1: one-cycle pulse on every applied tick.
- `min_pulse` out 1: one-cycle pulse when seconds wrap 59→00.
- `hour_pulse` out 1: one-cycle pulse when minutes wrap 59→00.
- `day_pulse` out 1: one-cycle pulse when hours wrap 23→00.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation

- **Synchroniser and edge detect:** `secclk` → s1 → s2 → s3.
  - `tick = s2 & ~s3 & run_en`.
  - Falling edges are ignored.
- **Reset:** on `reset`=1 at a clk edge:
  - s1, s2 and s3 are set to 1, so a `secclk` held high after reset does not produce a spurious tick.
  - `hours`, `minutes` and `seconds` are set to 00.
  - All pulse outputs and `load_err` are set to 0.
  - `reset` overrides `load` and `tick`.
- **Tick, no load:** units digit of seconds +1.
  - Units 9 → 0 with tens +1.
  - Seconds 59 → 00 carries into minutes, with the same rule.
  - Minutes 59 → 00 carries into hours.
  - Hours 23 → 00 (units 3 with tens 2 wraps both digits; units 9 → 0 otherwise).
  - All carries ripple in the same cycle: 23:59:59 → 00:00:00 in one clock edge.
- **Pulses:** registered and asserted on the same edge the counters update.
  - `sec_pulse` fires on every applied tick.
  - `min_pulse`, `hour_pulse` and `day_pulse` fire only on their respective wraps, so all four can fire together.
- **Load validation:** a load is valid when every BCD digit is ≤ 9, `ld_h` ≤ 0x23, `ld_m` ≤ 0x59 and `ld_s` ≤ 0x59.
  - Valid: the counters take the loaded values on the next edge; no carry pulses fire.
  - Invalid: the counters are unchanged, `load_err` = 1 for one cycle, and a tick in the same cycle is still applied normally.
- **Simultaneous valid load and tick:** the load wins. The tick is discarded and `sec_pulse` stays 0.
- **`run_en`=0:** ticks are discarded, not queued. Loads are still accepted. The edge-detect chain keeps shifting, so re-enabling does not produce a stale tick.
- **`load` held high:** every cycle is a load request, and the counters hold the loaded value.

## Timing

- **Tick latency:** if `secclk` is first sampled high at clk edge N (s1 ← 1), then:
  - `tick` is combinationally high between edges N+1 and N+2;
  - counters and `sec_pulse` update at edge N+2;
  - `sec_pulse` is high for exactly one cycle.
- **Load latency:** 1 clock. `load` sampled at edge M → outputs show the new time after edge M. `load_err` follows the same timing.
- **Pulse width:** every pulse output is high for exactly one `clk` cycle per event.
- **Minimum `secclk` high/low time:** 3 `clk` cycles. Shorter pulses may be missed; this is allowed.
- **Reset:** outputs hold reset values from the first edge with `reset`=1 until the first edge after `reset` returns to 0.
- **Reset mid-operation:** a tick in flight in the synchroniser is lost; no tick is generated after reset releases with `secclk` high.

## Test plan

- **Reset then count:** assert `reset` 2 cycles with `secclk`=1; release; toggle `secclk` with a 10-cycle period, 5 rising edges, `run_en`=1 → no tick at release; `seconds`=0x05, 5 `sec_pulse`s, each 2 edges after s1 samples high.
- **Full rollover:** load 23:59:58, then 2 ticks → 23:59:59, then 00:00:00; `sec_pulse`, `min_pulse`, `hour_pulse` and `day_pulse` are all high on the same cycle of the second tick.
- **Invalid loads:** `ld_h`=0x24, then `ld_m`=0x5A, then `ld_s`=0x60 → each gives `load_err` for one cycle and the time is unchanged. `ld_h`=0x19 is accepted.
- **Collision:**
  - valid load 12:00:00 on the same cycle as a tick → time = 12:00:00 and no `sec_pulse`;
  - invalid load on the same cycle as a tick → tick applied, `load_err` = 1.
- **Pause:** `run_en`=0 across 3 `secclk` rising edges → time frozen. Raise `run_en` with `secclk` high → no tick until the next rising edge.
- **Reset mid-tick:** assert `reset` the cycle after s1 samples high → all outputs are 0 and no `sec_pulse` fires after release.
